// File: rtl/conv3x3_prog.sv
// conv3x3_prog: programmable signed 3x3 convolution with double-buffered kernel, rounded shift and pixel clamp; CONV3X3_PROG_ABS_EN selects |sum| edge-magnitude mode.
module conv3x3_prog #(
    parameter int PIX_W   = 8,
    parameter int COEF_W  = 8,
    parameter int SHIFT_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [9*PIX_W-1:0]   i_pixel_data,
    input  logic                 i_pixel_data_valid,
    input  logic                 i_coef_we,
    input  logic [3:0]           i_coef_addr,
    input  logic [COEF_W-1:0]    i_coef_data,
    input  logic                 i_coef_commit,
    output logic [PIX_W-1:0]     o_convolved_data,
    output logic                 o_convolved_data_valid,
    output logic                 o_sat
);
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int SUM_W  = PIX_W + COEF_W + 5;
    localparam int RND_W  = SUM_W + 1;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic signed [RND_W-1:0] R_MAX = (RND_W'(1) << PIX_W) - RND_W'(1);

    logic signed [COEF_W-1:0] shd_coef_q [9];
    logic signed [COEF_W-1:0] shd_coef_d [9];
    logic signed [COEF_W-1:0] act_coef_q [9];
    logic signed [COEF_W-1:0] act_coef_d [9];
    logic [SHIFT_W-1:0]       shd_shift_q, shd_shift_d;
    logic [SHIFT_W-1:0]       act_shift_q, act_shift_d;

    logic signed [PROD_W-1:0] prod_q [9];
    logic signed [PROD_W-1:0] prod_d [9];
    logic                     v1_q, v1_d;
    logic [SHIFT_W-1:0]       sh1_q, sh1_d;

    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic                     v2_q, v2_d;
    logic [SHIFT_W-1:0]       sh2_q, sh2_d;

    logic [PIX_W-1:0]         data_q, data_d;
    logic                     sat_q, sat_d;
    logic                     v3_q, v3_d;

    logic signed [RND_W-1:0]  mag, rnd, r;

    // Kernel banks: commit copies the pre-edge shadow, so a same-cycle write only reaches shadow
    always_comb begin
        shd_coef_d  = shd_coef_q;
        shd_shift_d = shd_shift_q;
        act_coef_d  = act_coef_q;
        act_shift_d = act_shift_q;
        if (i_coef_commit) begin
            act_coef_d  = shd_coef_q;
            act_shift_d = shd_shift_q;
        end
        if (i_coef_we && i_coef_addr == 4'd9)
            shd_shift_d = i_coef_data[SHIFT_W-1:0];
        else if (i_coef_we && i_coef_addr < 4'd9)
            shd_coef_d[i_coef_addr] = i_coef_data;
    end

    // Stage 1: per-tap signed coefficient times zero-extended pixel, using the active bank
    always_comb begin
        for (int k = 0; k < 9; k++)
            prod_d[k] = PROD_W'(act_coef_q[k]) * PROD_W'($signed({1'b0, i_pixel_data[k*PIX_W +: PIX_W]}));
        v1_d  = i_pixel_data_valid;
        sh1_d = act_shift_q;
    end

    // Stage 2: sign-extended sum of the nine products
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++)
            sum_d = sum_d + SUM_W'(prod_q[k]);
        v2_d  = v1_q;
        sh2_d = sh1_q;
    end

    // Stage 3: optional magnitude, round-half-up arithmetic shift, clamp to pixel range
    always_comb begin
        mag = RND_W'(sum_q);
`ifdef CONV3X3_PROG_ABS_EN
        mag = (sum_q < 0) ? -mag : mag;
`endif
        rnd    = (sh2_q == '0) ? '0 : (RND_W'(1) << (sh2_q - SHIFT_W'(1)));
        r      = (mag + rnd) >>> sh2_q;
        data_d = !v2_q ? data_q : r[RND_W-1] ? '0 : (r > R_MAX) ? PIX_MAX : r[PIX_W-1:0];
        sat_d  = v2_q && (r[RND_W-1] || r > R_MAX);
        v3_d   = v2_q;
    end

    // State registers; reset restores the identity kernel in both banks and flushes the pipe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 9; k++) begin
                shd_coef_q[k] <= (k == 4) ? COEF_W'(1) : '0;
                act_coef_q[k] <= (k == 4) ? COEF_W'(1) : '0;
                prod_q[k]     <= '0;
            end
            shd_shift_q <= '0;
            act_shift_q <= '0;
            v1_q        <= 1'b0;
            sh1_q       <= '0;
            sum_q       <= '0;
            v2_q        <= 1'b0;
            sh2_q       <= '0;
            data_q      <= '0;
            sat_q       <= 1'b0;
            v3_q        <= 1'b0;
        end else begin
            shd_coef_q  <= shd_coef_d;
            act_coef_q  <= act_coef_d;
            shd_shift_q <= shd_shift_d;
            act_shift_q <= act_shift_d;
            prod_q      <= prod_d;
            v1_q        <= v1_d;
            sh1_q       <= sh1_d;
            sum_q       <= sum_d;
            v2_q        <= v2_d;
            sh2_q       <= sh2_d;
            data_q      <= data_d;
            sat_q       <= sat_d;
            v3_q        <= v3_d;
        end
    end

    assign o_convolved_data       = data_q;
    assign o_convolved_data_valid = v3_q;
    assign o_sat                  = sat_q;
endmodule

// File: tb/tb_conv3x3_prog.sv
// tb_conv3x3_prog: directed plus randomized stimulus against an arithmetic reference of the programmable 3x3 convolution.
module tb_conv3x3_prog;
    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] pix;
    logic        pix_v;
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  cdata;
    logic        commit;
    logic [7:0]  out_data;
    logic        out_v;
    logic        out_sat;

    conv3x3_prog dut (
        .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_pixel_data_valid(pix_v),
        .i_coef_we(we), .i_coef_addr(addr), .i_coef_data(cdata), .i_coef_commit(commit),
        .o_convolved_data(out_data), .o_convolved_data_valid(out_v), .o_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int data; bit sat; } exp_t;
    exp_t q[$];
    int shd_c[9], act_c[9], shd_s, act_s;
    int cyc = 0, last = 0, errors = 0, checks = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Reference: weighted sum, optional magnitude, round-half-up divide by 2^s, clamp
    task automatic ref_px(input logic [71:0] w, output int r, output bit sat);
        longint sum = 0;
        logic [7:0] p;
        for (int k = 0; k < 9; k++) begin
            p = w[k*8 +: 8];
            sum += longint'(act_c[k]) * longint'(p);
        end
`ifdef CONV3X3_PROG_ABS_EN
        if (sum < 0) sum = -sum;
`endif
        if (act_s > 0) sum = (sum + (longint'(1) << (act_s - 1))) >>> act_s;
        sat = (sum < 0) || (sum > 255);
        r = (sum < 0) ? 0 : (sum > 255) ? 255 : int'(sum);
    endtask

    task automatic step(input bit v, input logic [71:0] w, input bit wr_en, input int a, input int d,
                        input bit cm, input bit rs);
        exp_t e;
        pix = w; pix_v = v; we = wr_en; addr = 4'(a); cdata = 8'(d); commit = cm; rst = rs;
        @(posedge clk);
        cyc++;
        if (rs) begin
            q.delete();
            last = 0;
            for (int k = 0; k < 9; k++) begin shd_c[k] = (k == 4); act_c[k] = (k == 4); end
            shd_s = 0; act_s = 0;
        end else begin
            if (v) begin
                e.due = cyc + 2;
                ref_px(w, e.data, e.sat);
                q.push_back(e);
            end
            if (cm) begin act_c = shd_c; act_s = shd_s; end
            if (wr_en && a == 9) shd_s = d & 15;
            else if (wr_en && a < 9) shd_c[a] = int'($signed(8'(d)));
        end
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("valid", out_v, 1);
            check("data", out_data, e.data);
            check("sat", out_sat, e.sat);
            last = e.data;
        end else begin
            check("idle_valid", out_v, 0);
            check("idle_sat", out_sat, 0);
            check("hold", out_data, last);
        end
    endtask

    function automatic logic [71:0] rnd_win();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom);
        return w;
    endfunction

    function automatic logic [71:0] flat(input int v);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v);
        return w;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, rnd_win(), 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        step(0, rnd_win(), 1, a, d, 0, 0);
    endtask

    task automatic win(input logic [71:0] w);
        step(1, w, 0, 0, 0, 0, 0);
    endtask

    int sob[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    logic [71:0] w, wm;

    initial begin
        step(0, '0, 0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 0, 1);
        check("rst_data", out_data, 0);
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(10 * (k + 1));
        win(w);
        idle(4);
        for (int k = 0; k < 9; k++) wr(k, 1);
        wr(9, 3);
        step(0, rnd_win(), 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) win(flat(16));
        idle(4);
        for (int k = 0; k < 9; k++) wr(k, sob[k]);
        wr(9, 0);
        step(0, rnd_win(), 0, 0, 0, 1, 0);
        for (int k = 0; k < 9; k++) begin
            w[k*8 +: 8]  = (k % 3 == 0) ? 8'd0 : (k % 3 == 2) ? 8'd255 : 8'($urandom);
            wm[k*8 +: 8] = (k % 3 == 0) ? 8'd255 : (k % 3 == 2) ? 8'd0 : w[k*8 +: 8];
        end
        win(w);
        win(wm);
        idle(4);
        step(0, '0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 9; k++) wr(k, 1);
        wr(9, 3);
        step(1, flat(16), 0, 0, 0, 1, 0);
        win(flat(16));
        idle(4);
        step(0, '0, 0, 0, 0, 0, 1);
        step(0, rnd_win(), 1, 12, 8'h7F, 0, 0);
        step(0, rnd_win(), 0, 0, 0, 1, 0);
        win(rnd_win());
        idle(4);
        for (int k = 0; k < 9; k++) wr(k, $urandom_range(0, 3));
        wr(9, 2);
        step(0, rnd_win(), 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) win(rnd_win());
        step(0, '0, 0, 0, 0, 0, 1);
        idle(4);
        win(rnd_win());
        idle(4);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 9) < 7, rnd_win(), $urandom_range(0, 9) < 3, $urandom_range(0, 15),
                 $urandom_range(0, 255), $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        idle(4);
        check("drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
